// File: rtl/conditional_relay_pipe.sv
// conditional_relay_pipe: multi-lane, tag-tracked delay line.
// The pipe shifts only when a new entry is accepted or a flush is requested.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (dominates valid/flush)
//   in         LANES*WIDTH input word, lane l at [l*WIDTH +: WIDTH]
//   valid      new entry this cycle, always accepted
//   lane_en    per-lane data mask for the entry written on valid
//   flush      advance one stage, inserting a bubble when valid=0
//   out        data of the last stage, all lanes
//   out_valid  tag of the last stage
//   out_fresh  pulse: last advance moved a tagged entry into the last stage
//   occupancy  number of tagged stages
module conditional_relay_pipe #(
    parameter int CYCLE = 1,
    parameter int WIDTH = 11,
    parameter int LANES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES*WIDTH-1:0]     in,
    input  logic                       valid,
    input  logic [LANES-1:0]           lane_en,
    input  logic                       flush,
    output logic [LANES*WIDTH-1:0]     out,
    output logic                       out_valid,
    output logic                       out_fresh,
    output logic [$clog2(CYCLE+1)-1:0] occupancy
);

    localparam int DW = LANES * WIDTH;
    localparam int OW = $clog2(CYCLE + 1);

    logic [DW-1:0]    r_data [CYCLE];
    logic [CYCLE-1:0] r_tag;
    logic             r_fresh;
    logic [OW-1:0]    r_occ;

    logic             w_adv;
    logic [DW-1:0]    w_in_masked;
    logic             w_fresh_src;
    logic [OW-1:0]    w_occ_next;

    assign w_adv = valid | flush;

    // Disabled lanes, and every lane of a bubble, enter as zero.
    always_comb begin
        w_in_masked = '0;
        for (int l = 0; l < LANES; l++) begin
            if (valid && lane_en[l]) begin
                w_in_masked[l*WIDTH +: WIDTH] = in[l*WIDTH +: WIDTH];
            end
        end
    end

    // Tag that will land in the last stage on this advance.
    generate
        if (CYCLE == 1) begin : g_fresh_single
            assign w_fresh_src = valid;
        end else begin : g_fresh_multi
            assign w_fresh_src = r_tag[CYCLE-2];
        end
    endgenerate

    // A full pipe with valid=1 adds one and drops one, so no overflow.
    assign w_occ_next = r_occ + OW'(valid) - OW'(r_tag[CYCLE-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CYCLE; i++) begin
                r_data[i] <= '0;
            end
            r_tag   <= '0;
            r_fresh <= 1'b0;
            r_occ   <= '0;
        end else begin
            r_fresh <= w_adv & w_fresh_src;
            if (w_adv) begin
                r_data[0] <= w_in_masked;
                for (int i = 1; i < CYCLE; i++) begin
                    r_data[i] <= r_data[i-1];
                end
                r_tag <= (r_tag << 1) | CYCLE'(valid);
                r_occ <= w_occ_next;
            end
        end
    end

    assign out       = r_data[CYCLE-1];
    assign out_valid = r_tag[CYCLE-1];
    assign out_fresh = r_fresh;
    assign occupancy = r_occ;

endmodule

// File: tb/tb_conditional_relay_pipe.sv
// Bench for conditional_relay_pipe: directed scenarios plus random traffic
// against a queue-based reference model, on a 4x2-lane and a 1x1-lane DUT.
module tb_conditional_relay_pipe;

    localparam int W  = 11;
    localparam int CA = 4;
    localparam int LA = 2;
    localparam int CB = 1;
    localparam int LB = 1;

    logic clk;
    int   total = 0;
    int   bad   = 0;

    logic            a_rst, a_valid, a_flush;
    logic [LA*W-1:0] a_in;
    logic [LA-1:0]   a_lane_en;
    logic [LA*W-1:0] a_out;
    logic            a_ov, a_fr;
    logic [2:0]      a_occ;

    logic            b_rst, b_valid, b_flush;
    logic [LB*W-1:0] b_in;
    logic [LB-1:0]   b_lane_en;
    logic [LB*W-1:0] b_out;
    logic            b_ov, b_fr;
    logic [0:0]      b_occ;

    conditional_relay_pipe #(.CYCLE(CA), .WIDTH(W), .LANES(LA)) u_a (
        .clk(clk), .rst(a_rst), .in(a_in), .valid(a_valid),
        .lane_en(a_lane_en), .flush(a_flush), .out(a_out),
        .out_valid(a_ov), .out_fresh(a_fr), .occupancy(a_occ)
    );

    conditional_relay_pipe #(.CYCLE(CB), .WIDTH(W), .LANES(LB)) u_b (
        .clk(clk), .rst(b_rst), .in(b_in), .valid(b_valid),
        .lane_en(b_lane_en), .flush(b_flush), .out(b_out),
        .out_valid(b_ov), .out_fresh(b_fr), .occupancy(b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each pipe is a fixed-length queue, front = stage 0.
    logic [LA*W-1:0] qa_d[$];
    bit              qa_t[$];
    bit              ma_fr;
    logic [LB*W-1:0] qb_d[$];
    bit              qb_t[$];
    bit              mb_fr;

    function automatic int pop_a();
        int n = 0;
        foreach (qa_t[i]) n += int'(qa_t[i]);
        return n;
    endfunction

    function automatic int pop_b();
        int n = 0;
        foreach (qb_t[i]) n += int'(qb_t[i]);
        return n;
    endfunction

    task automatic step();
        logic [LA*W-1:0] wa;
        logic [LB*W-1:0] wb;
        @(posedge clk);
        if (a_rst) begin
            qa_d = {};
            qa_t = {};
            for (int i = 0; i < CA; i++) begin
                qa_d.push_back('0);
                qa_t.push_back(1'b0);
            end
            ma_fr = 1'b0;
        end else if (a_valid || a_flush) begin
            wa = '0;
            for (int l = 0; l < LA; l++)
                if (a_valid && a_lane_en[l]) wa[l*W +: W] = a_in[l*W +: W];
            qa_d.push_front(wa);
            qa_t.push_front(a_valid);
            void'(qa_d.pop_back());
            void'(qa_t.pop_back());
            ma_fr = qa_t[CA-1];
        end else begin
            ma_fr = 1'b0;
        end
        if (b_rst) begin
            qb_d = {};
            qb_t = {};
            for (int i = 0; i < CB; i++) begin
                qb_d.push_back('0);
                qb_t.push_back(1'b0);
            end
            mb_fr = 1'b0;
        end else if (b_valid || b_flush) begin
            wb = '0;
            for (int l = 0; l < LB; l++)
                if (b_valid && b_lane_en[l]) wb[l*W +: W] = b_in[l*W +: W];
            qb_d.push_front(wb);
            qb_t.push_front(b_valid);
            void'(qb_d.pop_back());
            void'(qb_t.pop_back());
            mb_fr = qb_t[CB-1];
        end else begin
            mb_fr = 1'b0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        a_rst = 0; a_valid = 0; a_flush = 0; a_in = '0; a_lane_en = '1;
        b_rst = 0; b_valid = 0; b_flush = 0; b_in = '0; b_lane_en = '1;
    endtask

    task automatic reset_a();
        a_rst = 1;
        step();
        a_rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        a_rst = 1; b_rst = 1;
        step();
        step();
        a_rst = 0; b_rst = 0;
        total++;
        if ({a_out, a_ov, a_fr, a_occ} !== '0) begin
            bad++;
            $display("FAIL reset_a got out=%h ov=%b fr=%b occ=%0d exp all 0",
                     a_out, a_ov, a_fr, a_occ);
        end
        total++;
        if ({b_out, b_ov, b_fr, b_occ} !== '0) begin
            bad++;
            $display("FAIL reset_b got out=%h ov=%b fr=%b occ=%0d exp all 0",
                     b_out, b_ov, b_fr, b_occ);
        end
    endtask

    task automatic test_reset_midstream();
        logic [LA*W-1:0] vals [3];
        vals[0] = {11'h022, 11'h011};
        vals[1] = {11'h044, 11'h033};
        vals[2] = {11'h066, 11'h055};
        for (int k = 0; k < 3; k++) begin
            a_valid = 1; a_in = vals[k];
            step();
        end
        a_valid = 0;
        a_rst = 1;
        step();
        a_rst = 0;
        total++;
        if ({a_out, a_ov, a_occ} !== '0) begin
            bad++;
            $display("FAIL mid_reset got out=%h ov=%b occ=%0d exp 0/0/0",
                     a_out, a_ov, a_occ);
        end
        a_flush = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (a_fr !== 1'b0 || a_ov !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_drain[%0d] got fr=%b ov=%b exp 0/0",
                         k, a_fr, a_ov);
            end
        end
        a_flush = 0;
    endtask

    task automatic test_stream();
        int eocc;
        reset_a();
        for (int k = 1; k <= 8; k++) begin
            a_valid = 1;
            a_in = {11'(k + 'h100), 11'(k)};
            step();
            eocc = (k < 4) ? k : 4;
            total++;
            if (k >= 4) begin
                if (a_out !== {11'(k - 3 + 'h100), 11'(k - 3)} ||
                    a_ov !== 1'b1 || a_fr !== 1'b1 || a_occ !== 3'(eocc)) begin
                    bad++;
                    $display("FAIL stream[%0d] got out=%h ov=%b fr=%b occ=%0d exp out=%h 1 1 %0d",
                             k, a_out, a_ov, a_fr, a_occ,
                             {11'(k - 3 + 'h100), 11'(k - 3)}, eocc);
                end
            end else begin
                if (a_ov !== 1'b0 || a_fr !== 1'b0 || a_occ !== 3'(eocc)) begin
                    bad++;
                    $display("FAIL stream_fill[%0d] got ov=%b fr=%b occ=%0d exp 0 0 %0d",
                             k, a_ov, a_fr, a_occ, eocc);
                end
            end
        end
        a_valid = 0;
    endtask

    task automatic test_stall();
        logic [LA*W-1:0] hold_out;
        logic            hold_ov;
        reset_a();
        a_valid = 1; a_in = {11'h0, 11'h0AA}; step();
        a_in = {11'h0, 11'h0BB}; step();
        a_valid = 0;
        hold_out = a_out;
        hold_ov  = a_ov;
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (a_out !== hold_out || a_ov !== hold_ov ||
                a_occ !== 3'd2 || a_fr !== 1'b0) begin
                bad++;
                $display("FAIL stall[%0d] got out=%h ov=%b occ=%0d fr=%b exp out=%h ov=%b occ=2 fr=0",
                         k, a_out, a_ov, a_occ, a_fr, hold_out, hold_ov);
            end
        end
        a_valid = 1; a_in = {11'h0, 11'h0CC}; step();
        a_in = {11'h0, 11'h0DD}; step();
        a_valid = 0;
        total++;
        if (a_out[W-1:0] !== 11'h0AA || a_ov !== 1'b1 ||
            a_fr !== 1'b1 || a_occ !== 3'd4) begin
            bad++;
            $display("FAIL stall_resume got lane0=%h ov=%b fr=%b occ=%0d exp 0aa 1 1 4",
                     a_out[W-1:0], a_ov, a_fr, a_occ);
        end
    endtask

    task automatic test_drain();
        logic [W-1:0] eo [4];
        logic [3:0]   ev;
        logic [3:0]   ef;
        logic [2:0]   eocc [4];
        eo[0] = 11'h000; eo[1] = 11'h101; eo[2] = 11'h102; eo[3] = 11'h000;
        ev = 4'b0110;
        ef = 4'b0110;
        eocc[0] = 3'd2; eocc[1] = 3'd2; eocc[2] = 3'd1; eocc[3] = 3'd0;
        reset_a();
        a_valid = 1; a_in = {11'h0, 11'h101}; step();
        a_in = {11'h0, 11'h102}; step();
        a_valid = 0;
        total++;
        if (a_occ !== 3'd2) begin
            bad++;
            $display("FAIL drain_fill got occ=%0d exp 2", a_occ);
        end
        a_flush = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (a_out !== {11'h0, eo[k]} || a_ov !== ev[k] ||
                a_fr !== ef[k] || a_occ !== eocc[k]) begin
                bad++;
                $display("FAIL drain[%0d] got out=%h ov=%b fr=%b occ=%0d exp out=%h ov=%b fr=%b occ=%0d",
                         k, a_out, a_ov, a_fr, a_occ, {11'h0, eo[k]},
                         ev[k], ef[k], eocc[k]);
            end
        end
        a_flush = 0;
    endtask

    task automatic test_lane_mask();
        reset_a();
        a_valid = 1; a_lane_en = 2'b01; a_in = {11'h155, 11'h3FF};
        step();
        a_valid = 0; a_lane_en = 2'b11; a_flush = 1;
        for (int k = 0; k < CA - 1; k++) step();
        a_flush = 0;
        total++;
        if (a_out !== {11'h000, 11'h3FF} || a_ov !== 1'b1) begin
            bad++;
            $display("FAIL lane_mask got out=%h ov=%b exp out=%h ov=1",
                     a_out, a_ov, {11'h000, 11'h3FF});
        end
    endtask

    task automatic test_valid_flush_c1();
        b_rst = 1; step(); b_rst = 0;
        b_valid = 1; b_flush = 1; b_in = 11'h7FF;
        step();
        b_valid = 0;
        total++;
        if (b_out !== 11'h7FF || b_ov !== 1'b1 ||
            b_fr !== 1'b1 || b_occ !== 1'b1) begin
            bad++;
            $display("FAIL c1_both got out=%h ov=%b fr=%b occ=%0d exp 7ff 1 1 1",
                     b_out, b_ov, b_fr, b_occ);
        end
        step();
        b_flush = 0;
        total++;
        if (b_out !== 11'h000 || b_ov !== 1'b0 ||
            b_fr !== 1'b0 || b_occ !== 1'b0) begin
            bad++;
            $display("FAIL c1_flush got out=%h ov=%b fr=%b occ=%0d exp 0 0 0 0",
                     b_out, b_ov, b_fr, b_occ);
        end
    endtask

    task automatic test_random();
        logic [LA*W+4:0] ea;
        logic [LB*W+2:0] eb;
        for (int k = 0; k < 400; k++) begin
            a_rst     = ($urandom_range(0, 59) == 0);
            a_valid   = $urandom_range(0, 1) == 1;
            a_flush   = $urandom_range(0, 2) == 0;
            a_lane_en = LA'($urandom);
            a_in      = LA*W'($urandom);
            b_rst     = ($urandom_range(0, 59) == 0);
            b_valid   = $urandom_range(0, 1) == 1;
            b_flush   = $urandom_range(0, 2) == 0;
            b_lane_en = LB'($urandom);
            b_in      = LB*W'($urandom);
            step();
            ea = {qa_d[CA-1], qa_t[CA-1], ma_fr, 3'(pop_a())};
            eb = {qb_d[CB-1], qb_t[CB-1], mb_fr, 1'(pop_b())};
            total++;
            if ({a_out, a_ov, a_fr, a_occ} !== ea) begin
                bad++;
                $display("FAIL rand_a[%0d] got %h exp %h",
                         k, {a_out, a_ov, a_fr, a_occ}, ea);
            end
            total++;
            if ({b_out, b_ov, b_fr, b_occ} !== eb) begin
                bad++;
                $display("FAIL rand_b[%0d] got %h exp %h",
                         k, {b_out, b_ov, b_fr, b_occ}, eb);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        a_rst = 1; b_rst = 1;
        test_reset();
        test_reset_midstream();
        test_stream();
        test_stall();
        test_drain();
        test_lane_mask();
        test_valid_flush_c1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conditional_relay_pipe.md
Name: conditional_relay_pipe

Overview:
- Multi-lane, tag-tracked successor to the single-lane conditional relay.
- A CYCLE-deep shift pipeline that advances only on an accepted `valid` or an explicit `flush`.
- Each stage carries a valid tag, so downstream logic knows which output words are real and how many entries are in flight.
- Used wherever sorter/merge stages need a delay line that stalls with input cadence and can be drained at end of stream.

Parameters:
- CYCLE, 1, pipeline depth in stages (≥1).
- WIDTH, 11, data width per lane.
- LANES, 1, number of parallel lanes sharing one advance/tag chain (≥1).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  LANES*WIDTH  input word; lane l at bits [l*WIDTH +: WIDTH].
- valid  input  1  new entry presented this cycle; always accepted (no backpressure).
- lane_en  input  LANES  per-lane data mask for the entry written on `valid`.
- flush  input  1  advance the pipeline one stage, inserting a bubble if `valid`=0.
- out  output  LANES*WIDTH  stage CYCLE-1 data, all lanes.
- out_valid  output  1  tag of stage CYCLE-1.
- out_fresh  output  1  one-cycle pulse: an advance in the previous cycle placed a tagged entry into stage CYCLE-1.
- occupancy  output  $clog2(CYCLE+1)  number of tagged stages.

Behaviour:
- **Reset.**
  - rst=1 at a clock edge clears, in that edge:
    - all stage data (every lane) to 0;
    - all tags to 0;
    - out_valid=0, out_fresh=0, occupancy=0.
  - rst dominates valid and flush.
  - Mid-stream reset discards all in-flight entries. Nothing is emitted after reset until new valids propagate through.
- **Advance condition.** advance = valid | flush.
  - With no advance, all data, tags and occupancy hold, and out_fresh=0 next cycle.
- **On advance:**
  - Stage i (i≥1) data and tag load from stage i-1, all lanes.
  - Stage 0 lane l loads in lane l if valid & lane_en[l], else 0.
  - Stage 0 tag loads `valid`.
  - valid and flush together behave as valid alone: the entry is inserted with tag=1.
  - If lane_en=0 with valid=1, the entry is still tagged and its data is all zero.
- **Latency.**
  - An entry written on valid reaches `out` after exactly CYCLE further advances.
  - With valid held high, this is CYCLE cycles: registered output, no combinational in→out path.
  - CYCLE=1 is a single register stage.
- **out_fresh.** Registered. Set to 1 iff advance occurred and tag[CYCLE-2] was 1 before the edge; for CYCLE=1, iff valid=1. Otherwise 0.
- **occupancy.**
  - Registered; equals the popcount of tags at all times.
  - On advance: occupancy_next = occupancy + valid − old tag[CYCLE-1].
  - Never exceeds CYCLE and never underflows. Full pipe with valid=1 stays at CYCLE.
- **Drain.** Asserting flush with valid=0 for CYCLE cycles empties the pipe: occupancy reaches 0, and tagged entries emerge in order, each with an out_fresh pulse.
- **Data without tags.** Untagged stages carry data; bubbles are 0, but stale data is not guaranteed beyond that. Consumers must qualify `out` with out_valid.

Test Plan:
1. **Reset mid-stream.** CYCLE=4, WIDTH=11, LANES=2; push 3 valids (0x011/0x022, 0x033/0x044, 0x055/0x066), then rst=1 one cycle → next cycle out=0, out_valid=0, occupancy=0; no out_fresh afterwards until new data.
2. **Continuous stream.** valid held high with in = k (lane 0) and k+0x100 (lane 1) for k=1..8 → out first shows k=1 exactly 4 cycles after its input cycle; out_fresh high every cycle from then on; occupancy saturates at 4.
3. **Stall hold.** Push 0x0AA, 0x0BB, then valid=0 and flush=0 for 10 cycles → out, out_valid, occupancy (=2) frozen. Two further valids (0x0CC, 0x0DD) → out=0x0AA, out_valid=1, out_fresh=1.
4. **Flush drain with bubbles.** Pipe holds 0x101, 0x102 (occupancy 2), then flush=1 alone for 4 cycles → 0x101 then 0x102 appear at out with out_fresh pulses, each followed by bubbles with out_valid=0; occupancy ends at 0.
5. **Lane mask.** LANES=2; valid=1, lane_en=2'b01, in lanes 0x3FF/0x155 → after CYCLE advances, lane 0=0x3FF, lane 1=0, out_valid=1.
6. **Simultaneous valid+flush, CYCLE=1.** valid=1 and flush=1, in=0x7FF → next cycle out=0x7FF, out_valid=1, out_fresh=1, occupancy=1. Then flush alone → out_valid=0, occupancy=0.
